// File: rtl/rgb2gray_seq_pkg.sv
// rtl/rgb2gray_seq_pkg.sv - shared widths, BT.601 weights, FSM encoding and rounding helper
package rgb2gray_seq_pkg;

    localparam int PIX_W_DEF  = 8;
    localparam int FRAC_W_DEF = 16;

    localparam int COEF_R_DEF = 19595;
    localparam int COEF_G_DEF = 38470;
    localparam int COEF_B_DEF = 7471;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_R = 3'd1,
        ST_MUL_G = 3'd2,
        ST_MUL_B = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Half an output LSB in the UQ0.frac_w domain, added before truncation
    function automatic logic [31:0] round_half(input int frac_w);
        return 32'd1 << (frac_w - 1);
    endfunction

endpackage

// File: rtl/rgb2gray_seq_pix_frac_mul.sv
// rtl/rgb2gray_seq_pix_frac_mul.sv - combinational pixel by UQ0.FRAC_W fraction multiplier
module pix_frac_mul
    import rgb2gray_seq_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic [PIX_W-1:0]        i_pix,
    input  logic [FRAC_W-1:0]       i_frac,
    output logic [PIX_W+FRAC_W-1:0] o_prod
);

    assign o_prod = (PIX_W+FRAC_W)'(i_pix) * (PIX_W+FRAC_W)'(i_frac);

endmodule

// File: rtl/rgb2gray_seq.sv
// rtl/rgb2gray_seq.sv - streaming RGB to gray converter sharing one multiplier over three cycles
module rgb2gray_seq
    import rgb2gray_seq_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int COEF_R = COEF_R_DEF,
    parameter int COEF_G = COEF_G_DEF,
    parameter int COEF_B = COEF_B_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_r,
    input  logic [PIX_W-1:0] in_g,
    input  logic [PIX_W-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_gray,
    output logic             out_last
);

    localparam int PROD_W = PIX_W + FRAC_W;
    localparam int ACC_W  = PROD_W + 2;
    localparam logic [FRAC_W-1:0] CR  = FRAC_W'(COEF_R);
    localparam logic [FRAC_W-1:0] CG  = FRAC_W'(COEF_G);
    localparam logic [FRAC_W-1:0] CB  = FRAC_W'(COEF_B);
    localparam logic [ACC_W-1:0]  RND = ACC_W'(round_half(FRAC_W));

    state_t             r_state;
    logic [PIX_W-1:0]   r_r;
    logic [PIX_W-1:0]   r_g;
    logic [PIX_W-1:0]   r_b;
    logic               r_last;
    logic [ACC_W-1:0]   r_acc;

    logic [PIX_W-1:0]   w_pix;
    logic [FRAC_W-1:0]  w_coef;
    logic [PROD_W-1:0]  w_prod;
    logic [ACC_W-1:0]   w_sum;
    logic [ACC_W-1:0]   w_final;
    logic [PIX_W+1:0]   w_int;
    logic [PIX_W-1:0]   w_gray;

    // Operand select for the shared multiplier; blue is the MUL_B and idle default
    always_comb begin
        w_pix  = r_b;
        w_coef = CB;
        case (r_state)
            ST_MUL_R: begin
                w_pix  = r_r;
                w_coef = CR;
            end
            ST_MUL_G: begin
                w_pix  = r_g;
                w_coef = CG;
            end
            default: ;
        endcase
    end

    pix_frac_mul #(
        .PIX_W  (PIX_W),
        .FRAC_W (FRAC_W)
    ) u_mul (
        .i_pix  (w_pix),
        .i_frac (w_coef),
        .o_prod (w_prod)
    );

    assign w_sum   = r_acc + ACC_W'(w_prod);
    assign w_final = w_sum + RND;
    assign w_int   = (PIX_W+2)'(w_final >> FRAC_W);
    // Only reachable when the coefficients sum above 1.0
    assign w_gray  = (|w_int[PIX_W+1:PIX_W]) ? {PIX_W{1'b1}} : w_int[PIX_W-1:0];

    assign in_ready = (r_state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
            r_last    <= 1'b0;
            r_acc     <= '0;
            out_valid <= 1'b0;
            out_gray  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_r     <= in_r;
                        r_g     <= in_g;
                        r_b     <= in_b;
                        r_last  <= in_last;
                        r_acc   <= '0;
                        r_state <= ST_MUL_R;
                    end
                end
                ST_MUL_R: begin
                    r_acc   <= ACC_W'(w_prod);
                    r_state <= ST_MUL_G;
                end
                ST_MUL_G: begin
                    r_acc   <= w_sum;
                    r_state <= ST_MUL_B;
                end
                ST_MUL_B: begin
                    out_gray  <= w_gray;
                    out_last  <= r_last;
                    out_valid <= 1'b1;
                    r_state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb2gray_seq.sv
// tb/tb_rgb2gray_seq.sv - self-checking bench for rgb2gray_seq
module tb_rgb2gray_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [7:0] in_r, in_g, in_b, out_gray;

    logic       s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_last;
    logic [7:0] s_in_r, s_in_g, s_in_b, s_out_gray;

    int n_checks = 0;
    int n_errs   = 0;
    logic [7:0] decoy_r, decoy_g, decoy_b;

    always #5 clk = ~clk;

    rgb2gray_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_gray(out_gray), .out_last(out_last)
    );

    rgb2gray_seq #(.COEF_R(65535), .COEF_G(65535), .COEF_B(65535)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_r(s_in_r), .in_g(s_in_g), .in_b(s_in_b), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_gray(s_out_gray), .out_last(s_out_last)
    );

    function automatic int model(int r, int g, int b, int cr, int cg, int cb);
        int v;
        v = (r * cr + g * cg + b * cb + 32768) / 65536;
        return (v > 255) ? 255 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic do_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic last, input int exp_gray, input int stall);
        int lat;
        int lows;
        logic [7:0] held;
        in_valid  = 1'b1;
        in_r = r; in_g = g; in_b = b; in_last = last;
        out_ready = (stall == 0);
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 0;
        lows = 0;
        while (!out_valid && lat < 10) begin
            if (!in_ready) lows++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!in_ready) lows++;
        chk("latency", lat, 3);
        chk("gray", out_gray, exp_gray);
        chk("last", out_last, last);
        held = out_gray;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_r = decoy_r; in_g = decoy_g; in_b = decoy_b; in_last = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (s == stall - 1) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_gray", out_gray, held);
                chk("stall_last", out_last, last);
                chk("stall_in_ready", in_ready, 0);
            end else if (!out_valid || out_gray !== held || in_ready) begin
                chk("stall_hold", {out_valid, in_ready, out_gray}, {1'b1, 1'b0, held});
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("valid_drop", out_valid, 0);
        chk("back_idle", in_ready, 1);
        if (stall == 0) chk("in_ready_low_cycles", lows, 4);
    endtask

    initial begin
        int lat;
        logic [7:0] r, g, b;
        logic l;
        rst = 1'b1;
        in_valid = 1'b0; in_r = '0; in_g = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_r = '0; s_in_g = '0; s_in_b = '0; s_in_last = 1'b0;
        s_out_ready = 1'b1;
        decoy_r = 8'd200; decoy_g = 8'd100; decoy_b = 8'd50;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_gray", out_gray, 0);
        chk("rst_out_last", out_last, 0);

        do_pix(8'd255, 8'd255, 8'd255, 1'b0, 255, 0);
        do_pix(8'd255, 8'd0,   8'd0,   1'b0, 76,  0);
        do_pix(8'd0,   8'd255, 8'd0,   1'b0, 150, 0);
        do_pix(8'd0,   8'd0,   8'd255, 1'b0, 29,  0);
        do_pix(8'd0,   8'd0,   8'd0,   1'b1, 0,   0);
        do_pix(8'd10,  8'd20,  8'd30,  1'b0, model(10, 20, 30, 19595, 38470, 7471), 0);

        do_pix(8'd50, 8'd60, 8'd70, 1'b1, model(50, 60, 70, 19595, 38470, 7471), 10);
        do_pix(decoy_r, decoy_g, decoy_b, 1'b0, model(200, 100, 50, 19595, 38470, 7471), 0);

        // Reset while the pixel sits in MUL_G
        in_valid = 1'b1; in_r = 8'd9; in_g = 8'd9; in_b = 8'd9; in_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("midrst_no_output", out_valid, 0);
        do_pix(8'd100, 8'd100, 8'd100, 1'b0, 100, 0);

        for (int i = 0; i < 20; i++) begin
            r = 8'($urandom);
            g = 8'($urandom);
            b = 8'($urandom);
            l = 1'($urandom);
            do_pix(r, g, b, l, model(r, g, b, 19595, 38470, 7471), int'($urandom_range(0, 2)));
        end

        s_in_valid = 1'b1; s_in_r = 8'd255; s_in_g = 8'd255; s_in_b = 8'd255; s_in_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("sat_latency", lat, 3);
        chk("sat_gray", s_out_gray, model(255, 255, 255, 65535, 65535, 65535));
        chk("sat_last", s_out_last, 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
